// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes, data-memory freeze with timeout, and perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2,
        ERR_ALT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic load_use;
    logic hold;
    logic advance;

    always_comb begin
        load_use = id_valid & ex_mem_read & (ex_rt != '0)
                 & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
        // Codes 2 and 3 both behave as ERR.
        hold = state_q[1]
             | ((state_q == RUN) & dmem_req & ~dmem_ready)
             | ((state_q == MEM_WAIT) & ~dmem_ready);
        // A taken branch squashes the dependent ID instruction, so no stall.
        advance = ~hold & ~(load_use & ~ex_branch_taken);

        pc_we      = ~rst & advance;
        ifid_we    = ~rst & advance;
        ifid_flush = ~rst & ex_branch_taken & ~hold;
        idex_flush = ~rst & (ex_branch_taken | load_use) & ~hold;
        pipe_hold  = rst | hold;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d = MEM_WAIT;
                    timer_d = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_we && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (ifid_flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign err         = err_q;
    assign state_o     = state_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline. Drives write-enables and flushes into the PC, IF/ID and ID/EX registers, and a freeze into all downstream pipeline registers.
- Detects load-use hazards between ID and EX and flushes wrong-path instructions on a taken branch resolved in EX.
- Freezes the pipeline while data memory is not ready, with a timeout that raises a sticky error.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
REG_W, 5, register specifier width
TIMEOUT, 64, maximum MEM_WAIT cycles before error (must be at least 2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_W  ID source register rs
id_rt  in  REG_W  ID source register rt
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  EX stage holds a load (lw)
ex_rt  in  REG_W  destination register of the EX-stage load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
dmem_req  in  1  MEM stage is accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  load NOP into IF/ID
idex_flush  out  1  zero the ID/EX control_signals (bubble)
pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB registers
err  out  1  sticky memory-timeout error
state_o  out  2  current FSM state
stall_count  out  CNT_W  cycles with pc_we=0
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- FSM states:
  - RUN=0
  - MEM_WAIT=1
  - ERR=2
  - Code 3 is unreachable and is decoded as ERR.
- Hazard term: load_use = id_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Hold term: hold = (RUN & dmem_req & !dmem_ready) | (MEM_WAIT & !dmem_ready) | ERR.
- Outputs are combinational from the current state and inputs (zero latency):
  - pipe_hold = hold
  - ifid_flush = ex_branch_taken & !hold
  - idex_flush = (ex_branch_taken | load_use) & !hold
  - pc_we = ifid_we = !hold & !(load_use & !ex_branch_taken)
- Priority: hold > branch flush > load-use.
  - Branch together with load-use: the ID instruction is wrong-path, so flush only. No stall is taken and the PC advances to the target.
- Load-use inserts exactly one bubble. On the next cycle the bubble sits in EX, so ex_mem_read=0 and load_use clears by itself.
- Transitions:
  - RUN -> MEM_WAIT when dmem_req & !dmem_ready. The timer is set to 1.
  - MEM_WAIT -> RUN when dmem_ready. In that same cycle hold=0 and branch/load-use are evaluated normally. A branch in EX stays asserted across the freeze because EX is frozen.
  - MEM_WAIT, !dmem_ready: the timer increments. If timer == TIMEOUT-1, go to ERR and set err=1.
  - ERR: pipe_hold=1, all enables 0, flushes 0. Exit is by rst only.
- Counters:
  - stall_count increments on every non-reset cycle with pc_we=0 (includes hold and ERR).
  - flush_count increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones and do not wrap.
- Reset: async assert forces state=RUN, timer=0, err=0, stall_count=0, flush_count=0.
- While rst is high, the outputs are forced to pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=0, pipe_hold=1.
- Reset asserted mid-MEM_WAIT abandons the wait. The first cycle after release is RUN.
- Register 0 never creates a hazard. A load to $0 never stalls.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_valid=1 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 for that cycle only; stall_count goes 0->1.
- No hazard via $0 or an unused rt: ex_rt=0, id_rs=0 -> pc_we=1. Separately, ex_rt=7, id_rt=7, id_uses_rt=0 -> pc_we=1, idex_flush=0.
- Branch with load-use: ex_branch_taken=1 plus load_use conditions -> pc_we=1, ifid_flush=1, idex_flush=1; flush_count=1, stall_count unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> pipe_hold=1 and pc_we=0 for 3 cycles, state_o=1; the ready cycle has pipe_hold=0 and state_o returns to 0; stall_count=3.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> err=1 and state_o=2 after 4 hold cycles; pipe_hold stays 1 when dmem_ready later rises; rst clears err.
- Async reset mid-MEM_WAIT: assert rst between clock edges -> state_o=0 and counters 0 immediately; pipe_hold=1 until rst is deasserted.
